// File: rtl/eeprom_access_sequencer.sv
// eeprom_access_sequencer
// Turns single-byte read/write requests into AT25010 engine command sequences.
//   read  : READ
//   write : WREN -> WRITE -> RDSR polls (POLL_GAP idle cycles apart) until the
//           busy bit clears or POLL_LIMIT polls have been made.
// Optional build macro WRITE_VERIFY_EN: after the poll clears, a write also reads
// the byte back and reports code 3 when the readback differs from the written data.
module eeprom_access_sequencer #(
   parameter int POLL_LIMIT = 1024,
   parameter int POLL_GAP   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_code,
   output logic       busy,
   output logic       eep_cmd_valid,
   input  logic       eep_cmd_ready,
   output logic [2:0] eep_cmd_type,
   output logic [6:0] eep_cmd_addr,
   output logic [7:0] eep_cmd_wdata,
   input  logic [7:0] eep_cmd_rdata,
   input  logic       eep_cmd_done,
   input  logic       eep_cmd_error
);

   // Poll counter holds the value POLL_LIMIT itself, hence clog2+1 bits.
   localparam int PW = $clog2(POLL_LIMIT) + 1;
   localparam int GW = $clog2(POLL_GAP) + 1;
   localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   localparam logic [2:0] CMD_WREN  = 3'd0;
   localparam logic [2:0] CMD_RDSR  = 3'd2;
   localparam logic [2:0] CMD_READ  = 3'd4;
   localparam logic [2:0] CMD_WRITE = 3'd5;

   localparam logic [1:0] RC_OK      = 2'd0;
   localparam logic [1:0] RC_ENGINE  = 2'd1;
   localparam logic [1:0] RC_TIMEOUT = 2'd2;
`ifdef WRITE_VERIFY_EN
   localparam logic [1:0] RC_VERIFY  = 2'd3;
`endif

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_RESP} state_t;
   typedef enum logic [2:0] {STEP_WREN, STEP_WRITE, STEP_POLL, STEP_READ, STEP_VERIFY} step_t;

   state_t        state, state_n;
   step_t         step, step_n;
   logic [6:0]    addr_q, addr_n;
   logic [7:0]    wdata_q, wdata_n;
   logic [PW-1:0] poll_cnt, poll_n, poll_inc;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [7:0]    rdata_q, rdata_n;
   logic [1:0]    code_q, code_n;

   // State and datapath registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         step     <= STEP_READ;
         addr_q   <= '0;
         wdata_q  <= '0;
         poll_cnt <= '0;
         gap_cnt  <= '0;
         rdata_q  <= '0;
         code_q   <= '0;
      end else begin
         state    <= state_n;
         step     <= step_n;
         addr_q   <= addr_n;
         wdata_q  <= wdata_n;
         poll_cnt <= poll_n;
         gap_cnt  <= gap_n;
         rdata_q  <= rdata_n;
         code_q   <= code_n;
      end
   end

   // Saturating poll count as it will be after the current RDSR completes.
   assign poll_inc = (poll_cnt == POLL_MAX) ? poll_cnt : poll_cnt + 1'b1;

   // Next-state logic: walks the step sequence and builds the response.
   // NOTE: every variable gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      step_n  = step;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      poll_n  = poll_cnt;
      gap_n   = gap_cnt;
      rdata_n = rdata_q;
      code_n  = code_q;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               addr_n  = req_addr;
               wdata_n = req_wdata;
               step_n  = req_write ? STEP_WREN : STEP_READ;
               poll_n  = '0;
               gap_n   = '0;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (eep_cmd_ready) state_n = S_WAIT;
         end
         S_WAIT: begin
            // Error has priority over a simultaneous done.
            if (eep_cmd_error) begin
               rdata_n = '0;
               code_n  = RC_ENGINE;
               state_n = S_RESP;
            end else if (eep_cmd_done) begin
               case (step)
                  STEP_WREN: begin
                     step_n  = STEP_WRITE;
                     state_n = S_ISSUE;
                  end
                  STEP_WRITE: begin
                     step_n  = STEP_POLL;
                     state_n = S_ISSUE;
                  end
                  STEP_POLL: begin
                     poll_n = poll_inc;
                     if (!eep_cmd_rdata[0]) begin
`ifdef WRITE_VERIFY_EN
                        step_n  = STEP_VERIFY;
                        state_n = S_ISSUE;
`else
                        rdata_n = eep_cmd_rdata;
                        code_n  = RC_OK;
                        state_n = S_RESP;
`endif
                     end else if (poll_inc == POLL_MAX) begin
                        rdata_n = eep_cmd_rdata;
                        code_n  = RC_TIMEOUT;
                        state_n = S_RESP;
                     end else begin
                        gap_n   = '0;
                        state_n = S_GAP;
                     end
                  end
`ifdef WRITE_VERIFY_EN
                  STEP_VERIFY: begin
                     rdata_n = eep_cmd_rdata;
                     code_n  = (eep_cmd_rdata == wdata_q) ? RC_OK : RC_VERIFY;
                     state_n = S_RESP;
                  end
`endif
                  default: begin
                     rdata_n = eep_cmd_rdata;
                     code_n  = RC_OK;
                     state_n = S_RESP;
                  end
               endcase
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               gap_n   = '0;
               state_n = S_ISSUE;
            end else begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Command port decode: fields are driven only while a command is offered.
   always_comb begin
      eep_cmd_type  = '0;
      eep_cmd_addr  = '0;
      eep_cmd_wdata = '0;
      if (state == S_ISSUE) begin
         case (step)
            STEP_WREN:  eep_cmd_type = CMD_WREN;
            STEP_WRITE: begin
               eep_cmd_type  = CMD_WRITE;
               eep_cmd_addr  = addr_q;
               eep_cmd_wdata = wdata_q;
            end
            STEP_POLL:  eep_cmd_type = CMD_RDSR;
            default: begin
               eep_cmd_type = CMD_READ;
               eep_cmd_addr = addr_q;
            end
         endcase
      end
   end

   assign req_ready     = (state == S_IDLE);
   assign busy          = (state != S_IDLE);
   assign eep_cmd_valid = (state == S_ISSUE);
   assign rsp_valid     = (state == S_RESP);
   assign rsp_rdata     = rdata_q;
   assign rsp_code      = code_q;

endmodule
